// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared RAM.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-latency arbiter sharing one single-port RAM between fetch and data requesters.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned AW         = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         perf_conflicts_o,
    output logic [15:0]         perf_fetch_wait_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [3:0] LatInit   = 4'(MEM_LAT - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e        state_q;
    logic          ownerData_q;
    logic [3:0]    cnt_q;
    logic [3:0]    starve_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [31:0]   ifRdata_q;
    logic [31:0]   memRdata_q;
    logic          ifReady_q;
    logic          memReady_q;
    logic          grantData;

    // Data wins a contest unless fetch has lost STARVE_MAX contests in a row.
    assign grantData = bus.mem_req && (!bus.if_req || (starve_q != StarveMax));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ownerData_q <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            ifRdata_q   <= '0;
            memRdata_q  <= '0;
            ifReady_q   <= 1'b0;
            memReady_q  <= 1'b0;
        end else begin
            ifReady_q  <= 1'b0;
            memReady_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantData) begin
                        ownerData_q <= 1'b1;
                        addr_q      <= bus.mem_addr;
                        we_q        <= bus.mem_we;
                        wdata_q     <= bus.mem_wdata;
                        cnt_q       <= LatInit;
                        state_q     <= ACCESS;
                        if (bus.if_req && (starve_q != StarveMax)) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (bus.if_req) begin
                        ownerData_q <= 1'b0;
                        addr_q      <= bus.if_addr;
                        we_q        <= 1'b0;
                        wdata_q     <= '0;
                        cnt_q       <= LatInit;
                        starve_q    <= '0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (ownerData_q) begin
                            memReady_q <= 1'b1;
                            if (!we_q) begin
                                memRdata_q <= bus.ram_rdata;
                            end
                        end else begin
                            ifReady_q <= 1'b1;
                            ifRdata_q <= bus.ram_rdata;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Enables decode only from flops so reset removes them without waiting for an edge.
    assign bus.ram_en    = (state_q == ACCESS);
    assign bus.ram_we    = (state_q == ACCESS) && we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.if_rdata  = ifRdata_q;
    assign bus.if_ready  = ifReady_q;
    assign bus.mem_rdata = memRdata_q;
    assign bus.mem_ready = memReady_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflicts_q;
    logic [15:0] fetchWait_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflicts_q <= '0;
            fetchWait_q <= '0;
        end else begin
            if ((state_q == IDLE) && bus.if_req && bus.mem_req && (conflicts_q != 16'hFFFF)) begin
                conflicts_q <= conflicts_q + 16'd1;
            end
            if (bus.if_req && !((state_q == RESP) && !ownerData_q) && (fetchWait_q != 16'hFFFF)) begin
                fetchWait_q <= fetchWait_q + 16'd1;
            end
        end
    end

    assign perf_conflicts_o  = conflicts_q;
    assign perf_fetch_wait_o = fetchWait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2).
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    mem_port_arbiter_if #(.AW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perfConflicts;
    logic [15:0] perfFetchWait;
`endif

    mem_port_arbiter #(
        .MEM_LAT   (2),
        .STARVE_MAX(2),
        .AW        (32)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflicts_o (perfConflicts),
        .perf_fetch_wait_o(perfFetchWait)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic memReq, input logic memWe,
                                 input logic [31:0] memAddr, input logic [31:0] memWdata);
        bus.if_req    = ifReq;
        bus.if_addr   = ifAddr;
        bus.mem_req   = memReq;
        bus.mem_we    = memWe;
        bus.mem_addr  = memAddr;
        bus.mem_wdata = memWdata;
    endtask

    // Advance until a ready pulse is seen; reports which side and how many edges it took.
    task automatic waitReady(output logic gotData, output int cycles);
        gotData = 1'b0;
        cycles  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (bus.if_ready || bus.mem_ready) begin
                gotData = bus.mem_ready;
                return;
            end
        end
        checkOutput("readyTimeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic gotData;
        int   cycles;
        logic expOrder [6];

        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        bus.ram_rdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        #12;
        checkOutput("rstRamEn",    bus.ram_en,    0);
        checkOutput("rstRamWe",    bus.ram_we,    0);
        checkOutput("rstRamAddr",  bus.ram_addr,  0);
        checkOutput("rstRamWdata", bus.ram_wdata, 0);
        checkOutput("rstIfReady",  bus.if_ready,  0);
        checkOutput("rstMemReady", bus.mem_ready, 0);
        checkOutput("rstIfRdata",  bus.if_rdata,  0);
        checkOutput("rstMemRdata", bus.mem_rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch-only read of 0x10.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t1Acc1En",   bus.ram_en,   1);
        checkOutput("t1Acc1Addr", bus.ram_addr, 32'h10);
        checkOutput("t1Acc1We",   bus.ram_we,   0);
        bus.ram_rdata = 32'h0BADF00D;
        tick();
        checkOutput("t1Acc2En", bus.ram_en, 1);
        bus.ram_rdata = 32'hDEADBEEF;
        tick();
        checkOutput("t1RespEn",      bus.ram_en,    0);
        checkOutput("t1IfReady",     bus.if_ready,  1);
        checkOutput("t1IfRdata",     bus.if_rdata,  32'hDEADBEEF);
        checkOutput("t1MemReady",    bus.mem_ready, 0);
        bus.if_req = 1'b0;
        tick();
        checkOutput("t1IfReadyDrop", bus.if_ready, 0);
        checkOutput("t1IdleEn",      bus.ram_en,   0);

        // Simultaneous requests: data write wins, fetch follows.
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h20, 32'h12345678);
        tick();
        checkOutput("t2WrEn",    bus.ram_en,    1);
        checkOutput("t2WrWe",    bus.ram_we,    1);
        checkOutput("t2WrAddr",  bus.ram_addr,  32'h20);
        checkOutput("t2WrWdata", bus.ram_wdata, 32'h12345678);
        bus.mem_addr  = 32'hFFFF_0000;
        bus.mem_wdata = 32'h0;
        tick();
        checkOutput("t2WrAddrLatched", bus.ram_addr, 32'h20);
        tick();
        checkOutput("t2MemReady", bus.mem_ready, 1);
        checkOutput("t2IfReady",  bus.if_ready,  0);
        checkOutput("t2MemRdataKept", bus.mem_rdata, 0);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        tick();
        tick();
        checkOutput("t2FetchAddr", bus.ram_addr, 32'h40);
        checkOutput("t2FetchWe",   bus.ram_we,   0);
        tick();
        tick();
        checkOutput("t2IfReadyAfter4", bus.if_ready, 1);
        bus.if_req = 1'b0;
        tick();

        // Continuous contention with STARVE_MAX=2.
        expOrder = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 6; i++) begin
            waitReady(gotData, cycles);
            checkOutput($sformatf("t3Grant%0d", i), gotData, expOrder[i]);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset during the second ACCESS cycle of a contested data write.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 32'h30, 32'hAAAA5555);
        tick();
        tick();
        checkOutput("t4Acc2We", bus.ram_we, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t4RstRamEn", bus.ram_en, 0);
        checkOutput("t4RstRamWe", bus.ram_we, 0);
        tick();
        checkOutput("t4RstNoReady", bus.mem_ready, 0);
        rst_n = 1'b1;
        expOrder = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            waitReady(gotData, cycles);
            checkOutput($sformatf("t4Grant%0d", i), gotData, expOrder[i]);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Data read withdrawn in its first ACCESS cycle still completes.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
        bus.ram_rdata = 32'hCAFEF00D;
        tick();
        checkOutput("t5Acc1Addr", bus.ram_addr, 32'h50);
        bus.mem_req = 1'b0;
        waitReady(gotData, cycles);
        checkOutput("t5ReadyData",  gotData, 1);
        checkOutput("t5ReadyDelay", cycles,  2);
        checkOutput("t5MemRdata",   bus.mem_rdata, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t5IdleReady%0d", i), bus.mem_ready, 0);
            checkOutput($sformatf("t5IdleEn%0d", i),    bus.ram_en,    0);
        end

`ifdef ARB_PERF_CNT_EN
        rst_n = 1'b0;
        #1;
        checkOutput("t6RstConflicts", perfConflicts, 0);
        checkOutput("t6RstFetchWait", perfFetchWait, 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            waitReady(gotData, cycles);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t6Conflicts", perfConflicts, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
